bp_gshare_spec: RTL and testbench
=================================

# bp_gshare_spec

Parametrised gshare branch direction predictor for the F stage: global history of configurable length XORed with fetch-PC bits indexes a table of configurable-width saturating counters. Prediction is registered one cycle after lookup. The global history is updated speculatively on every lookup and restored from a per-branch history snapshot on a resolved mispredict. Resolution updates arrive from the branch-resolve stage carrying the index and snapshot handed out at prediction time.

## Interface
- HIST_W, 6, global history register width; must satisfy 1 <= HIST_W <= IDX_W
- IDX_W, 6, PHT index width; the table has 2^IDX_W entries
- CNTR_W, 2, saturating counter width; must be >= 2
- PC_LSB, 2, lowest PC bit used for indexing
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- lookup_valid  in  1  a fetch lookup is requested this cycle
- lookup_pc  in  32  fetch PC of the lookup
- pred_valid  out  1  prediction outputs are valid (registered)
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_W  PHT index used; travels with the branch
- pred_hist  out  HIST_W  GHR value used to form pred_idx (pre-shift snapshot)
- upd_valid  in  1  a resolved branch updates the predictor
- upd_idx  in  IDX_W  pred_idx returned with the branch
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  actual direction differed from the prediction
- upd_hist  in  HIST_W  pred_hist returned with the branch

## Operation
- Index: idx = lookup_pc[PC_LSB +: IDX_W] XOR {(IDX_W-HIST_W) zeros, GHR}.
- Counters reset to weakly-not-taken, 2^(CNTR_W-1)-1 (2'b01 for CNTR_W=2). Prediction = counter MSB.
- PHT read is combinational from idx. pred_taken, pred_idx, and pred_hist are loaded at the edge ending the lookup cycle.
- Speculative history: on an accepted lookup, GHR <= {GHR[HIST_W-2:0], predicted bit}.
- Update: on upd_valid, counter[upd_idx] increments on upd_taken=1 and decrements on upd_taken=0, saturating at all-ones and at zero.
- Recovery: on upd_valid && upd_mispredict, GHR <= {upd_hist[HIST_W-2:0], upd_taken}.
- A lookup in the same cycle as a recovery is squashed: no GHR shift, pred_valid=0 next cycle. Fetch replays it.
- Lookup and update to the same index in one cycle: the lookup reads the old counter value (no bypass). The update is still applied.
- upd_valid with upd_mispredict=0 never touches the GHR.
- HIST_W=1: the shift degenerates to GHR <= new bit.

## Timing
- Lookup latency: 1 cycle. A lookup in cycle N drives pred_* in N+1.
- pred_valid follows lookup_valid delayed by one cycle, except on a squash. With no lookup, the pred_* data holds its last value.
- Back-to-back lookups: the lookup in N+1 sees the GHR already shifted by N.
- Update latency: an update in cycle M is visible to lookups from M+1.
- Recovery in M: a lookup in M+1 indexes with the restored GHR.
- Reset, including mid-operation: next cycle pred_valid=0, pred_taken=0, pred_idx=0, pred_hist=0, GHR=0, and all counters are weakly-not-taken. Lookups and updates in the reset cycle are ignored.

## Configuration
- BP_GSHARE_SPEC_HIST_EN defined: speculative GHR update and mispredict recovery, as described above.
- Not defined: non-speculative history.
  - Lookups never shift the GHR.
  - On upd_valid, GHR <= {GHR[HIST_W-2:0], upd_taken}.
  - upd_mispredict and upd_hist are ignored, and no lookup is squashed.
  - PHT update behaviour is unchanged.

## Structure
- Package bp_pkg holds:
  - default HIST_W, IDX_W, CNTR_W, and PC_LSB constants;
  - a function returning the counter reset value for a given CNTR_W;
  - a struct typedef for the prediction bundle {taken, idx, hist} as carried down the pipe.
- Sub-module bp_sat_cntr: a CNTR_W-bit saturating counter with synchronous reset to weakly-not-taken, an enable, and a direction input. The PHT is a generate array of these.

## Test plan
- Reset, then a lookup at PC 0x0000_0010 -> pred_taken=0, pred_idx=6'h04, pred_hist=0; with SPEC_HIST_EN, GHR becomes 0.
- Two taken updates to idx 4, then a lookup at PC 0x10 with GHR=0 -> pred_taken=1. A third taken update leaves the counter at 2'b11; two not-taken updates then give pred_taken=0.
- Four back-to-back lookups with all counters forced to 2'b11 -> pred_hist = 0, 1, 3, 7 on successive cycles.
- Mispredict update with upd_hist=6'b101010, upd_taken=1, plus a lookup in the same cycle -> pred_valid=0 next cycle; the next lookup shows pred_hist=6'b010101.
- Same-cycle lookup and taken update to one index starting at 2'b01 -> the lookup returns 0; a repeat lookup returns 1.
- Assert reset during a stream of lookups with GHR nonzero -> all outputs and the GHR are 0 next cycle, and every index predicts not-taken.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants, helpers and types for the gshare branch predictor.
package bp_pkg;

  // Default geometry of the predictor.
  localparam int unsigned DefHistW = 6;
  localparam int unsigned DefIdxW  = 6;
  localparam int unsigned DefCntrW = 2;
  localparam int unsigned DefPcLsb = 2;

  // Weakly-not-taken encoding: 2^(w-1)-1, the largest value whose MSB is still 0.
  function automatic int unsigned cntr_rst_val(input int unsigned cntr_w);
    return (1 << (cntr_w - 1)) - 1;
  endfunction

  // Prediction bundle as it travels down the pipe with the branch (default geometry).
  typedef struct packed {
    logic                taken;
    logic [DefIdxW-1:0]  idx;
    logic [DefHistW-1:0] hist;
  } pred_t;

endpackage

// File: rtl/bp_sat_cntr.sv
// Saturating up/down counter; one PHT entry. Resets to weakly-not-taken.
module bp_sat_cntr
  import bp_pkg::*;
#(
  parameter int unsigned CntrW = DefCntrW
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic up_i,
  output logic taken_o
);

  localparam logic [CntrW-1:0] RstVal = CntrW'(cntr_rst_val(CntrW));
  localparam logic [CntrW-1:0] MaxVal = '1;

  logic [CntrW-1:0] cnt_q, cnt_d;

  // Next count: step toward the resolved direction, clamped at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (up_i && (cnt_q != MaxVal)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!up_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= RstVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_o = cnt_q[CntrW-1];

endmodule

// File: rtl/bp_gshare_spec.sv
// Gshare direction predictor: GHR XOR PC bits index a table of saturating counters.
// Prediction is registered one cycle after the lookup.
// Define BP_GSHARE_SPEC_HIST_EN for speculative history with mispredict recovery;
// otherwise the history is shifted only by resolved branches.
module bp_gshare_spec
  import bp_pkg::*;
#(
  parameter int unsigned HistW = DefHistW,
  parameter int unsigned IdxW  = DefIdxW,
  parameter int unsigned CntrW = DefCntrW,
  parameter int unsigned PcLsb = DefPcLsb
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IdxW-1:0]  pred_idx_o,
  output logic [HistW-1:0] pred_hist_o,
  input  logic             upd_valid_i,
  input  logic [IdxW-1:0]  upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [HistW-1:0] upd_hist_i
);

  localparam int unsigned Entries = 1 << IdxW;

  logic [HistW-1:0]   ghr_q, ghr_d;
  logic [IdxW-1:0]    lookup_idx;
  logic               lookup_taken;
  logic               lookup_fire;
  logic               squash;
  logic [Entries-1:0] pht_taken;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [IdxW-1:0]  pred_idx_q;
  logic [HistW-1:0] pred_hist_q;

  // Only a window of the PC feeds the index.
  logic unused_pc;
  assign unused_pc = ^lookup_pc_i;

  assign lookup_idx   = lookup_pc_i[PcLsb +: IdxW] ^ IdxW'(ghr_q);
  // Read is combinational from the current table, so a same-cycle update is not seen.
  assign lookup_taken = pht_taken[lookup_idx];

  for (genvar i = 0; i < Entries; i++) begin : g_pht
    bp_sat_cntr #(
      .CntrW(CntrW)
    ) u_cntr (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (upd_valid_i && (upd_idx_i == IdxW'(i))),
      .up_i   (upd_taken_i),
      .taken_o(pht_taken[i])
    );
  end

`ifdef BP_GSHARE_SPEC_HIST_EN
  // A recovery in flight invalidates any lookup made with the wrong-path history.
  assign squash = upd_valid_i && upd_mispredict_i;

  // History: restore from the branch snapshot on mispredict, else shift in the prediction.
  always_comb begin
    ghr_d = ghr_q;
    if (squash) begin
      ghr_d = (upd_hist_i << 1) | HistW'(upd_taken_i);
    end else if (lookup_fire) begin
      ghr_d = (ghr_q << 1) | HistW'(lookup_taken);
    end
  end
`else
  assign squash = 1'b0;

  // Resolution-time history ignores the snapshot and mispredict flag.
  logic unused_upd;
  assign unused_upd = ^{upd_mispredict_i, upd_hist_i};

  // History: shift in every resolved direction.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) begin
      ghr_d = (ghr_q << 1) | HistW'(upd_taken_i);
    end
  end
`endif

  assign lookup_fire = lookup_valid_i && !squash;

  // History and prediction registers; prediction data holds when no lookup fires.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      pred_hist_q  <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= lookup_fire;
      if (lookup_fire) begin
        pred_taken_q <= lookup_taken;
        pred_idx_q   <= lookup_idx;
        pred_hist_q  <= ghr_q;
      end
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_idx_o   = pred_idx_q;
  assign pred_hist_o  = pred_hist_q;

endmodule

// File: tb/tb_bp_gshare_spec.sv
// Directed self-checking bench for bp_gshare_spec (default geometry).
module tb_bp_gshare_spec;

  localparam int unsigned HistW = 6;
  localparam int unsigned IdxW  = 6;
`ifdef BP_GSHARE_SPEC_HIST_EN
  localparam bit SpecHist = 1'b1;
`else
  localparam bit SpecHist = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [IdxW-1:0]  pred_idx;
  logic [HistW-1:0] pred_hist;
  logic             upd_valid;
  logic [IdxW-1:0]  upd_idx;
  logic             upd_taken;
  logic             upd_mispredict;
  logic [HistW-1:0] upd_hist;

  int checks   = 0;
  int failures = 0;

  // Expected global history as the bench understands it.
  logic [HistW-1:0] g;

  always #5 clk = ~clk;

  bp_gshare_spec u_dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .lookup_valid_i  (lookup_valid),
    .lookup_pc_i     (lookup_pc),
    .pred_valid_o    (pred_valid),
    .pred_taken_o    (pred_taken),
    .pred_idx_o      (pred_idx),
    .pred_hist_o     (pred_hist),
    .upd_valid_i     (upd_valid),
    .upd_idx_i       (upd_idx),
    .upd_taken_i     (upd_taken),
    .upd_mispredict_i(upd_mispredict),
    .upd_hist_i      (upd_hist)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one cycle with a lookup and a taken update to idx 4 that must be ignored.
  task automatic do_reset();
    reset        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h10;
    upd_valid    = 1'b1;
    upd_idx      = 6'h04;
    upd_taken    = 1'b1;
    tick();
    reset        = 1'b0;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    upd_taken    = 1'b0;
    g            = '0;
    chk("rst_valid", pred_valid, 0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_idx", pred_idx, 0);
    chk("rst_hist", pred_hist, 0);
  endtask

  // Lookup with a PC chosen so the index lands on idx under the expected history.
  task automatic lookup_at(input logic [IdxW-1:0] idx, input logic exp_taken, input string tag);
    lookup_valid = 1'b1;
    lookup_pc    = {24'h0, idx ^ g, 2'b00};
    tick();
    lookup_valid = 1'b0;
    chk({tag, "_valid"}, pred_valid, 1);
    chk({tag, "_idx"}, pred_idx, idx);
    chk({tag, "_hist"}, pred_hist, g);
    chk({tag, "_taken"}, pred_taken, exp_taken);
    if (SpecHist) g = {g[HistW-2:0], exp_taken};
  endtask

  task automatic update(input logic [IdxW-1:0] idx, input logic taken, input logic misp,
                        input logic [HistW-1:0] hist_v);
    upd_valid      = 1'b1;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_mispredict = misp;
    upd_hist       = hist_v;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    chk("upd_no_pred", pred_valid, 0);
    if (SpecHist) begin
      if (misp) g = {hist_v[HistW-2:0], taken};
    end else begin
      g = {g[HistW-2:0], taken};
    end
  endtask

  logic [HistW-1:0] bb_hist [4];

  initial begin
    bb_hist        = '{6'h00, 6'h01, 6'h03, 6'h07};
    reset          = 1'b1;
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    upd_valid      = 1'b0;
    upd_idx        = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    upd_hist       = '0;
    g              = '0;

    do_reset();

    // First lookup at PC 0x10 after reset.
    lookup_valid = 1'b1;
    lookup_pc    = 32'h10;
    tick();
    lookup_valid = 1'b0;
    chk("first_valid", pred_valid, 1);
    chk("first_taken", pred_taken, 0);
    chk("first_idx", pred_idx, 6'h04);
    chk("first_hist", pred_hist, 0);

    // Training and saturation of idx 4.
    update(6'h04, 1'b1, 1'b0, '0);
    update(6'h04, 1'b1, 1'b0, '0);
    lookup_at(6'h04, 1'b1, "train2");
    update(6'h04, 1'b1, 1'b0, '0);
    update(6'h04, 1'b0, 1'b0, '0);
    lookup_at(6'h04, 1'b1, "sat_hi");
    update(6'h04, 1'b0, 1'b0, '0);
    lookup_at(6'h04, 1'b0, "dec");
    update(6'h04, 1'b0, 1'b0, '0);
    update(6'h04, 1'b0, 1'b0, '0);
    update(6'h04, 1'b0, 1'b0, '0);
    update(6'h04, 1'b1, 1'b0, '0);
    lookup_at(6'h04, 1'b0, "sat_lo");

    // Back-to-back lookups hitting a strongly-taken entry.
    do_reset();
    update(6'h04, 1'b1, 1'b0, '0);
    update(6'h04, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      lookup_valid = 1'b1;
      lookup_pc    = {24'h0, 6'h04 ^ g, 2'b00};
      tick();
      chk("b2b_valid", pred_valid, 1);
      chk("b2b_idx", pred_idx, 6'h04);
      chk("b2b_taken", pred_taken, 1);
      chk("b2b_hist", pred_hist, SpecHist ? bb_hist[k] : 6'h03);
      if (SpecHist) g = {g[HistW-2:0], 1'b1};
    end
    lookup_valid = 1'b0;

    // Mispredict recovery with a colliding lookup.
    lookup_valid   = 1'b1;
    lookup_pc      = 32'h10;
    upd_valid      = 1'b1;
    upd_idx        = 6'h09;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    upd_hist       = 6'b101010;
    tick();
    lookup_valid   = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    chk("squash_valid", pred_valid, SpecHist ? 0 : 1);
    if (SpecHist) g = 6'b010101;
    else g = {g[HistW-2:0], 1'b1};
    lookup_at(6'h20, 1'b0, "recov");

    // Same-cycle lookup and update to one index: old value read.
    lookup_valid   = 1'b1;
    lookup_pc      = {24'h0, 6'h30 ^ g, 2'b00};
    upd_valid      = 1'b1;
    upd_idx        = 6'h30;
    upd_taken      = 1'b1;
    tick();
    lookup_valid   = 1'b0;
    upd_valid      = 1'b0;
    chk("same_valid", pred_valid, 1);
    chk("same_idx", pred_idx, 6'h30);
    chk("same_taken", pred_taken, 0);
    g = {g[HistW-2:0], SpecHist ? 1'b0 : 1'b1};
    lookup_at(6'h30, 1'b1, "same_after");

    // Reset in the middle of a lookup stream; every entry must read not-taken.
    lookup_valid = 1'b1;
    lookup_pc    = 32'h10;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      lookup_at(IdxW'(i), 1'b0, "post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
